// File: rtl/med_win_ctrl.sv
// 3x3 sliding-window former for a streaming median filter: two line buffers plus a column shift register.
// One-cycle pixel-to-window latency; pixel intake stalls while an unaccepted window is held.
module med_win_ctrl #(
  parameter int WIDTH    = 8,
  parameter int MAX_COLS = 1024,
  parameter int CW       = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CW-1:0]      cfg_cols,
  input  logic [CW-1:0]      cfg_rows,
  output logic               busy,
  output logic               frame_done,
  input  logic               pix_valid,
  input  logic [WIDTH-1:0]   pix_in,
  output logic               pix_ready,
  output logic               win_valid,
  input  logic               win_ready,
  output logic [9*WIDTH-1:0] win_data,
  output logic               win_last
);

  localparam int AW = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;
  localparam logic [CW:0] MAX_COLS_W = (CW+1)'(MAX_COLS);

  typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cols_q, cols_d, rows_q, rows_d;
  logic [CW-1:0]      col_q, col_d, row_q, row_d;
  // Previous two columns of the window, each packed {top, mid, bottom}
  logic [3*WIDTH-1:0] s1_q, s1_d, s2_q, s2_d;
  logic               win_valid_q, win_valid_d, win_last_q, win_last_d;
  logic [9*WIDTH-1:0] win_data_q, win_data_d;

  logic [WIDTH-1:0]   lb1 [MAX_COLS];
  logic [WIDTH-1:0]   lb2 [MAX_COLS];
  logic [AW-1:0]      lb_idx;
  logic [WIDTH-1:0]   up1, up2;
  logic               pix_acc, win_acc, cfg_ok, col_end, interior;

  assign lb_idx = col_q[AW-1:0];
  assign up1    = lb1[lb_idx];
  assign up2    = lb2[lb_idx];

  assign pix_ready  = ((state_q == FILL) || (state_q == RUN)) && (!win_valid_q || win_ready);
  assign pix_acc    = pix_valid && pix_ready;
  assign win_acc    = win_valid_q && win_ready;
  assign col_end    = (col_q == cols_q - CW'(1));
  assign interior   = (row_q >= CW'(2)) && (col_q >= CW'(2)) && (row_q < rows_q);
  assign cfg_ok     = (cfg_cols >= CW'(3)) && ({1'b0, cfg_cols} <= MAX_COLS_W) &&
                      (cfg_rows >= CW'(3));

  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == DONE);
  assign win_valid  = win_valid_q;
  assign win_data   = win_data_q;
  assign win_last   = win_last_q;

  always_comb begin
    state_d     = state_q;
    cols_d      = cols_q;
    rows_d      = rows_q;
    col_d       = col_q;
    row_d       = row_q;
    s1_d        = s1_q;
    s2_d        = s2_q;
    win_valid_d = win_valid_q;
    win_last_d  = win_last_q;
    win_data_d  = win_data_q;

    if (win_acc) begin
      win_valid_d = 1'b0;
      win_last_d  = 1'b0;
    end

    if (pix_acc) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_q + CW'(1);
        // Clearing the shift register at line end keeps windows within one line
        s1_d  = '0;
        s2_d  = '0;
      end else begin
        col_d = col_q + CW'(1);
        s1_d  = {up2, up1, pix_in};
        s2_d  = s1_q;
      end
      if (interior) begin
        win_valid_d = 1'b1;
        win_last_d  = col_end && (row_q == rows_q - CW'(1));
        win_data_d  = {s2_q[3*WIDTH-1:2*WIDTH], s1_q[3*WIDTH-1:2*WIDTH], up2,
                       s2_q[2*WIDTH-1:WIDTH],   s1_q[2*WIDTH-1:WIDTH],   up1,
                       s2_q[WIDTH-1:0],         s1_q[WIDTH-1:0],         pix_in};
      end
    end

    case (state_q)
      IDLE: begin
        if (start && cfg_ok) begin
          cols_d  = cfg_cols;
          rows_d  = cfg_rows;
          col_d   = '0;
          row_d   = '0;
          s1_d    = '0;
          s2_d    = '0;
          state_d = FILL;
        end
      end
      FILL: if (pix_acc && (row_q == CW'(1)) && col_end) state_d = RUN;
      RUN:  if (win_acc && win_last_q) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cols_q      <= '0;
      rows_q      <= '0;
      col_q       <= '0;
      row_q       <= '0;
      s1_q        <= '0;
      s2_q        <= '0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
      win_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cols_q      <= cols_d;
      rows_q      <= rows_d;
      col_q       <= col_d;
      row_q       <= row_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      win_valid_q <= win_valid_d;
      win_last_q  <= win_last_d;
      win_data_q  <= win_data_d;
    end
  end

  // Line buffers carry no reset; the FILL rows overwrite whatever they hold
  always_ff @(posedge clk) begin
    if (pix_acc) begin
      lb1[lb_idx] <= pix_in;
      lb2[lb_idx] <= up1;
    end
  end

endmodule
